// File: rtl/dram_queue_path_ctrl_pkg.sv
// Shared definitions for the DRAM queue ingress path: FSM encodings and ring arithmetic helpers.
package dram_queue_path_ctrl_pkg;

   typedef logic [1:0] path_state_t;

   localparam path_state_t StIdle    = 2'd0;
   localparam path_state_t StScPkt   = 2'd1;
   localparam path_state_t StDramPkt = 2'd2;

   // Pointer increment that wraps at size-1; also pulls a stale pointer back into a smaller ring.
   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned size);
      return (ptr + 32'd1 >= size) ? 32'd0 : ptr + 32'd1;
   endfunction

   // block_num==0 encodes the full 2**aw ring.
   function automatic int unsigned ring_size_of(input int unsigned block_num,
                                                input int unsigned aw);
      return (block_num == 32'd0) ? (32'd1 << aw) : block_num;
   endfunction

endpackage

// File: rtl/dram_queue_path_ctrl_block_ring.sv
// DRAM block ring bookkeeping: write/read slot pointers, committed and pending block counts,
// and the ring size, which may only change while the ring is completely empty.
module dram_queue_path_ctrl_block_ring
   import dram_queue_path_ctrl_pkg::*;
#(
   parameter int unsigned AW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          blk_close,
   input  logic          wr_done,
   input  logic          rd_done,
   input  logic          size_latch,
   input  logic [AW-1:0] block_num,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic [AW:0]   count,
   output logic [AW:0]   wr_pending,
   output logic [AW:0]   ring_size
);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   pend_q, pend_d;
   logic [AW:0]   size_q, size_d;
   logic          latch, wr_acc, rd_acc;

   always_comb begin
      latch  = size_latch && (count_q == '0) && (pend_q == '0);
      size_d = latch ? (AW+1)'(ring_size_of(32'(block_num), AW)) : size_q;

      // Done pulses with nothing outstanding are ignored.
      wr_acc = wr_done && (pend_q != '0);
      rd_acc = rd_done && (count_q != '0);

      pend_d = pend_q;
      if (blk_close && !wr_acc) begin
         pend_d = pend_q + 1'b1;
      end else if (!blk_close && wr_acc) begin
         pend_d = pend_q - 1'b1;
      end

      count_d = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - 1'b1;
      end

      wr_ptr_d = blk_close ? AW'(wrap_inc(32'(wr_ptr_q), 32'(size_d))) : wr_ptr_q;
      rd_ptr_d = rd_acc    ? AW'(wrap_inc(32'(rd_ptr_q), 32'(size_d))) : rd_ptr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pend_q   <= '0;
         size_q   <= {1'b1, {AW{1'b0}}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         size_q   <= size_d;
      end
   end

   assign wr_ptr     = wr_ptr_q;
   assign rd_ptr     = rd_ptr_q;
   assign count      = count_q;
   assign wr_pending = pend_q;
   assign ring_size  = size_d;

endmodule

// File: rtl/dram_queue_path_ctrl.sv
// Ingress steering for the DRAM output queue: routes whole packets to the shortcut FIFO or the
// DRAM write path, tracks partial-block fill and flushes idle partial blocks.
module dram_queue_path_ctrl
   import dram_queue_path_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH            = 64,
   parameter int unsigned CTRL_WIDTH            = 8,
   parameter int unsigned DRAM_BLOCK_ADDR_WIDTH = 3,
   parameter int unsigned BLOCK_WORDS           = 16,
   parameter int unsigned FLUSH_IDLE            = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [DATA_WIDTH-1:0]            in_data,
   input  logic [CTRL_WIDTH-1:0]            in_ctrl,
   input  logic                             in_wr,
   output logic                             in_rdy,
   output logic [DATA_WIDTH-1:0]            sc_data,
   output logic [CTRL_WIDTH-1:0]            sc_ctrl,
   output logic                             sc_wr,
   input  logic                             sc_rdy,
   output logic [DATA_WIDTH-1:0]            dw_data,
   output logic [CTRL_WIDTH-1:0]            dw_ctrl,
   output logic                             dw_wr,
   input  logic                             dw_rdy,
   output logic                             dw_flush,
   output logic [DRAM_BLOCK_ADDR_WIDTH-1:0] dw_block_addr,
   input  logic                             dw_block_done,
   output logic [DRAM_BLOCK_ADDR_WIDTH-1:0] dr_block_addr,
   output logic                             dr_block_valid,
   input  logic                             dr_block_done,
   input  logic                             shortcut_disable,
   input  logic [DRAM_BLOCK_ADDR_WIDTH-1:0] block_num,
   output logic                             input_words,
   output logic                             shortcut_words,
   output logic                             dram_wr_words
);

   localparam int unsigned AW  = DRAM_BLOCK_ADDR_WIDTH;
   localparam int unsigned BcW = $clog2(BLOCK_WORDS);
   localparam int unsigned IcW = $clog2(FLUSH_IDLE);

   path_state_t    state_q, state_d;
   logic           active_q;
   logic           last_zero_q, last_zero_d;
   logic [BcW-1:0] blk_cnt_q, blk_cnt_d;
   logic [IcW-1:0] idle_cnt_q, idle_cnt_d;
   logic           in_words_q, sc_words_q, dw_words_q;

   logic           sc_ok, space, use_sc, accept, eop, idle_ok, blk_close, size_latch;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count, wr_pending, ring_size;

   dram_queue_path_ctrl_block_ring #(
      .AW (AW)
   ) u_ring (
      .clk        (clk),
      .reset      (reset),
      .blk_close  (blk_close),
      .wr_done    (dw_block_done),
      .rd_done    (dr_block_done),
      .size_latch (size_latch),
      .block_num  (block_num),
      .wr_ptr     (wr_ptr),
      .rd_ptr     (rd_ptr),
      .count      (count),
      .wr_pending (wr_pending),
      .ring_size  (ring_size)
   );

   always_comb begin
      sc_ok  = !shortcut_disable && (count == '0) && (wr_pending == '0) && (blk_cnt_q == '0);
      // An open block always has room; otherwise a fresh slot must be free in the ring.
      space  = (blk_cnt_q != '0) ||
               (({1'b0, count} + {1'b0, wr_pending}) < {1'b0, ring_size});
      use_sc = (state_q == StIdle) ? sc_ok : (state_q == StScPkt);
      in_rdy = active_q && (use_sc ? sc_rdy : (dw_rdy && space));
      accept = in_wr && in_rdy;
      sc_wr  = accept && use_sc;
      dw_wr  = accept && !use_sc;
      eop    = (in_ctrl != '0) && last_zero_q;

      state_d = state_q;
      case (state_q)
         StIdle:             if (accept) state_d = use_sc ? StScPkt : StDramPkt;
         StScPkt, StDramPkt: if (accept && eop) state_d = StIdle;
         default:            state_d = StIdle;
      endcase
      last_zero_d = accept ? (in_ctrl == '0) : last_zero_q;

      idle_ok    = active_q && (state_q == StIdle) && (blk_cnt_q != '0) && !in_wr;
      dw_flush   = idle_ok && (idle_cnt_q == IcW'(FLUSH_IDLE - 1));
      idle_cnt_d = (idle_ok && !dw_flush) ? idle_cnt_q + 1'b1 : '0;

      blk_close  = dw_flush || (dw_wr && (blk_cnt_q == BcW'(BLOCK_WORDS - 1)));
      blk_cnt_d  = blk_close ? '0 : (dw_wr ? blk_cnt_q + 1'b1 : blk_cnt_q);
      size_latch = (state_q == StIdle) && (blk_cnt_q == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         active_q    <= 1'b0;
         last_zero_q <= 1'b0;
         blk_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         in_words_q  <= 1'b0;
         sc_words_q  <= 1'b0;
         dw_words_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         active_q    <= 1'b1;
         last_zero_q <= last_zero_d;
         blk_cnt_q   <= blk_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         in_words_q  <= accept;
         sc_words_q  <= sc_wr;
         dw_words_q  <= dw_wr;
      end
   end

   assign sc_data        = in_data;
   assign sc_ctrl        = in_ctrl;
   assign dw_data        = in_data;
   assign dw_ctrl        = in_ctrl;
   assign dw_block_addr  = wr_ptr;
   assign dr_block_addr  = rd_ptr;
   assign dr_block_valid = (count != '0);
   assign input_words    = in_words_q;
   assign shortcut_words = sc_words_q;
   assign dram_wr_words  = dw_words_q;

endmodule

// File: tb/tb_dram_queue_path_ctrl.sv
// Directed bench for dram_queue_path_ctrl: vector table for steering, sequences for ring corners.
module tb_dram_queue_path_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] in_data = '0;
   logic [7:0]  in_ctrl = '0;
   logic        in_wr = 1'b0;
   logic        in_rdy;
   logic [63:0] sc_data, dw_data;
   logic [7:0]  sc_ctrl, dw_ctrl;
   logic        sc_wr, dw_wr, dw_flush, dr_block_valid;
   logic        sc_rdy = 1'b1;
   logic        dw_rdy = 1'b1;
   logic [2:0]  dw_block_addr, dr_block_addr;
   logic        dw_block_done = 1'b0;
   logic        dr_block_done = 1'b0;
   logic        shortcut_disable = 1'b0;
   logic [2:0]  block_num = 3'd4;
   logic        input_words, shortcut_words, dram_wr_words;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   dram_queue_path_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .in_data          (in_data),
      .in_ctrl          (in_ctrl),
      .in_wr            (in_wr),
      .in_rdy           (in_rdy),
      .sc_data          (sc_data),
      .sc_ctrl          (sc_ctrl),
      .sc_wr            (sc_wr),
      .sc_rdy           (sc_rdy),
      .dw_data          (dw_data),
      .dw_ctrl          (dw_ctrl),
      .dw_wr            (dw_wr),
      .dw_rdy           (dw_rdy),
      .dw_flush         (dw_flush),
      .dw_block_addr    (dw_block_addr),
      .dw_block_done    (dw_block_done),
      .dr_block_addr    (dr_block_addr),
      .dr_block_valid   (dr_block_valid),
      .dr_block_done    (dr_block_done),
      .shortcut_disable (shortcut_disable),
      .block_num        (block_num),
      .input_words      (input_words),
      .shortcut_words   (shortcut_words),
      .dram_wr_words    (dram_wr_words)
   );

   typedef struct {
      logic       wr;
      logic [7:0] ctrl;
      logic       sc_rdy;
      logic       dw_rdy;
      logic       dis;
      logic       e_rdy;
      logic       e_sc;
      logic       e_dw;
      logic       e_scw;
      logic       e_inw;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs_now();
      return 32'({in_rdy, sc_wr, dw_wr, dw_flush, dr_block_valid, dw_block_addr, dr_block_addr,
                  input_words, shortcut_words, dram_wr_words});
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      in_wr = 1'b0;
      sc_rdy = 1'b1;
      dw_rdy = 1'b1;
      dw_block_done = 1'b0;
      dr_block_done = 1'b0;
      #1;
      chk("reset_outputs", outs_now(), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
   endtask

   // Offers len words; hdr marks the first word as a header, close ends it with an EOP word.
   task automatic send_pkt(input int len, input bit hdr, input bit close,
                           output int n_sc, output int n_dw);
      int i = 0;
      int stall = 0;
      n_sc = 0;
      n_dw = 0;
      while (i < len) begin
         @(negedge clk);
         in_wr = 1'b0;
         #1;
         if (in_rdy) begin
            in_ctrl = (i == 0 && hdr) ? 8'hff : ((i == len - 1 && close) ? 8'h80 : 8'h00);
            in_data = 64'(i);
            in_wr = 1'b1;
            #1;
            n_sc += int'(sc_wr);
            n_dw += int'(dw_wr);
            i++;
         end else begin
            stall++;
            if (stall > 300) begin
               chk("send_stall_timeout", 32'(i), 32'(len));
               break;
            end
         end
      end
      @(negedge clk);
      in_wr = 1'b0;
   endtask

   task automatic pulse_done(input logic dw, input logic dr);
      @(negedge clk);
      dw_block_done = dw;
      dr_block_done = dr;
      @(negedge clk);
      dw_block_done = 1'b0;
      dr_block_done = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_sc, n_dw, flushes, flush_at;
      int exp_addr[5];

      //            wr  ctrl   scr  dwr  dis  rdy  sc   dw   scw  inw
      vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 8'hff, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[3]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 8'hff, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_addr = '{0, 1, 2, 3, 0};

      // Steering table: shortcut packet, backpressure, path held mid-packet.
      block_num = 3'd4;
      shortcut_disable = 1'b0;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         in_wr = vecs[i].wr;
         in_ctrl = vecs[i].ctrl;
         sc_rdy = vecs[i].sc_rdy;
         dw_rdy = vecs[i].dw_rdy;
         shortcut_disable = vecs[i].dis;
         #1;
         chk($sformatf("vec%0d_in_rdy", i), 32'(in_rdy), 32'(vecs[i].e_rdy));
         chk($sformatf("vec%0d_sc_wr", i), 32'(sc_wr), 32'(vecs[i].e_sc));
         chk($sformatf("vec%0d_dw_wr", i), 32'(dw_wr), 32'(vecs[i].e_dw));
         chk($sformatf("vec%0d_shortcut_words", i), 32'(shortcut_words), 32'(vecs[i].e_scw));
         chk($sformatf("vec%0d_input_words", i), 32'(input_words), 32'(vecs[i].e_inw));
      end
      @(negedge clk);
      in_wr = 1'b0;

      // 40-word DRAM packet: blocks close at 16 and 32, partial flushed after 32 idle cycles.
      shortcut_disable = 1'b1;
      do_reset();
      send_pkt(40, 1'b1, 1'b1, n_sc, n_dw);
      chk("b_dw_count", 32'(n_dw), 32'd40);
      chk("b_sc_count", 32'(n_sc), 32'd0);
      chk("b_block_addr_after_pkt", 32'(dw_block_addr), 32'd2);
      flushes = 0;
      flush_at = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         if (k == 1) chk("b_dram_wr_words_pulse", 32'(dram_wr_words), 32'd1);
         if (k == 2) chk("b_dram_wr_words_clear", 32'(dram_wr_words), 32'd0);
         if (dw_flush) begin
            flushes++;
            if (flush_at == 0) flush_at = k;
         end
      end
      chk("b_flush_count", 32'(flushes), 32'd1);
      chk("b_flush_cycle", 32'(flush_at), 32'd32);
      chk("b_block_addr_after_flush", 32'(dw_block_addr), 32'd3);
      chk("b_no_committed", 32'(dr_block_valid), 32'd0);

      // Ring of 2: stall at word 33 until a committed block is read back.
      block_num = 3'd2;
      do_reset();
      send_pkt(32, 1'b1, 1'b0, n_sc, n_dw);
      chk("c_dw_first32", 32'(n_dw), 32'd32);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("c_stall%0d", k), 32'(in_rdy), 32'd0);
         @(negedge clk);
      end
      pulse_done(1'b1, 1'b0);
      pulse_done(1'b1, 1'b0);
      #1;
      chk("c_stall_ring_full", 32'(in_rdy), 32'd0);
      chk("c_valid", 32'(dr_block_valid), 32'd1);
      chk("c_rd_addr0", 32'(dr_block_addr), 32'd0);
      pulse_done(1'b0, 1'b1);
      #1;
      chk("c_resume", 32'(in_rdy), 32'd1);
      chk("c_rd_addr1", 32'(dr_block_addr), 32'd1);
      send_pkt(16, 1'b0, 1'b1, n_sc, n_dw);
      chk("c_dw_rest", 32'(n_dw), 32'd16);
      chk("c_wr_addr_wrapped", 32'(dw_block_addr), 32'd1);

      // Ring of 4: five blocks written and read one at a time, then simultaneous done pulses.
      block_num = 3'd4;
      do_reset();
      for (int b = 0; b < 5; b++) begin
         send_pkt(16, 1'b1, 1'b1, n_sc, n_dw);
         chk($sformatf("d_blk%0d_dw", b), 32'(n_dw), 32'd16);
         pulse_done(1'b1, 1'b0);
         #1;
         chk($sformatf("d_blk%0d_rd_addr", b), 32'(dr_block_addr), 32'(exp_addr[b]));
         chk($sformatf("d_blk%0d_valid", b), 32'(dr_block_valid), 32'd1);
         pulse_done(1'b0, 1'b1);
      end
      #1;
      chk("d_drained", 32'(dr_block_valid), 32'd0);
      send_pkt(16, 1'b1, 1'b1, n_sc, n_dw);
      pulse_done(1'b1, 1'b0);
      send_pkt(16, 1'b1, 1'b1, n_sc, n_dw);
      pulse_done(1'b1, 1'b1);
      #1;
      chk("d_both_valid", 32'(dr_block_valid), 32'd1);
      chk("d_both_rd_addr", 32'(dr_block_addr), 32'd2);

      // DRAM still holds a block: new packet must follow it; after drain the shortcut reopens.
      shortcut_disable = 1'b0;
      send_pkt(3, 1'b1, 1'b1, n_sc, n_dw);
      chk("e_dw_while_nonempty", 32'(n_dw), 32'd3);
      chk("e_sc_while_nonempty", 32'(n_sc), 32'd0);
      repeat (40) @(negedge clk);
      pulse_done(1'b1, 1'b0);
      pulse_done(1'b0, 1'b1);
      pulse_done(1'b0, 1'b1);
      #1;
      chk("e_drained", 32'(dr_block_valid), 32'd0);
      send_pkt(3, 1'b1, 1'b1, n_sc, n_dw);
      chk("e_sc_after_drain", 32'(n_sc), 32'd3);
      chk("e_dw_after_drain", 32'(n_dw), 32'd0);

      // Reset in the middle of a DRAM packet; next packet takes the shortcut.
      shortcut_disable = 1'b1;
      send_pkt(5, 1'b1, 1'b0, n_sc, n_dw);
      chk("f_partial_dw", 32'(n_dw), 32'd5);
      shortcut_disable = 1'b0;
      do_reset();
      send_pkt(3, 1'b1, 1'b1, n_sc, n_dw);
      chk("f_sc_after_reset", 32'(n_sc), 32'd3);
      chk("f_dw_after_reset", 32'(n_dw), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
